seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Programmable serial pattern detector; parametrised successor to the fixed 4-state Moore "1011" detector.
- Pattern value and length are loaded at run time. Overlapping or non-overlapping detection is selectable.
- Input is qualified by a valid strobe. Output is a registered detect pulse plus an optional saturating match counter.
- Sits on serial bit streams (framing/sync-word search) ahead of the deframer.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 16, width of match counter.
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  detector enable; low forces IDLE.
- cfg_load  in  1  one-cycle strobe; latches cfg_pattern/cfg_len/cfg_overlap and arms the detector.
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length, legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  seq_in is sampled only when high.
- seq_in  in  1  serial data bit.
- det_out  out  1  registered one-cycle detect pulse.
- armed  out  1  high in ACTIVE state.
- cfg_err  out  1  one-cycle pulse when cfg_load carries an illegal cfg_len.
- match_count  out  CNT_W  saturating count of detections (see Optional Feature).

Behaviour:
- Reset state: IDLE. det_out=0, armed=0, cfg_err=0, match_count=0, history=0, fill=0. Shadow config: pattern=0, len=1, overlap=0.
- FSM states are IDLE and ACTIVE.
- IDLE -> ACTIVE when cfg_load=1, en=1 and 1<=cfg_len<=MAX_LEN. On this transition: latch config, clear history and fill. match_count is not cleared.
- cfg_load with cfg_len==0 or cfg_len>MAX_LEN:
  - Config is not latched and the state is unchanged.
  - cfg_err pulses high in the next cycle.
- ACTIVE + cfg_load with legal length: relatch config, clear history and fill, stay ACTIVE.
- ACTIVE -> IDLE whenever en=0. In IDLE, in_valid is ignored and det_out is held 0.
- cfg_load and in_valid high in the same cycle: cfg_load wins and the seq_in bit is discarded.
- Per sampled bit (ACTIVE, in_valid=1, no cfg_load):
  - history <= {history[MAX_LEN-2:0], seq_in}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on next-state values: fill_next >= len and history_next[len-1:0] == pattern[len-1:0].
- On a match:
  - det_out is 1 for exactly the one cycle following the edge that sampled the final pattern bit (latency 1 clock from presentation of last bit).
  - Overlap=1: history and fill are kept, so a suffix can start the next match.
  - Overlap=0: fill is cleared to 0, so the next match needs len fresh bits.
- det_out=0 in every cycle with no sampled bit. Gaps in in_valid preserve history and fill unchanged.
- len=1: every sampled bit equal to pattern[0] produces a pulse, including back-to-back pulses on consecutive valid cycles.
- reset_n assertion mid-stream: all state returns immediately (asynchronously) to reset values, including config. The detector must be re-armed with cfg_load.

Optional Feature:
- Macro: SEQDET_MATCH_COUNT_EN.
- Defined:
  - match_count increments by 1 on every det_out pulse and saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset_n.
- Undefined: no counter register is built and match_count is tied to 0. Port list is unchanged.

Test Plan:
- pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 on consecutive valid cycles -> det_out pulses after bits 4 and 7; match_count=2.
- Same stream with overlap=0 -> single pulse after bit 4; match_count=1.
- pattern=4'b1011, len=4, overlap=1; bits 1,0,1,1 with in_valid low for 3 cycles between each bit -> one pulse, 1 cycle after the 4th valid bit; det_out=0 during gaps.
- len=1, pattern=1; stream 1,1,0,1 -> pulses after bits 1, 2 and 4. Second, separate run: cfg_len=0 with cfg_load -> cfg_err pulses, armed unchanged.
- MAX_LEN=8, len=8, pattern=8'hA5; stream 0xA5 MSB-first -> pulse after bit 8. Then assert cfg_load together with in_valid -> that bit is discarded and fill restarts at 0.
- CNT_W=4, macro defined; 20 matches -> match_count holds 15. Assert reset_n=0 mid-pattern -> all outputs 0 asynchronously, armed=0 until the next cfg_load.

Source files
------------

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if -- bus bundle for the programmable serial pattern detector.
//
// Carries everything except clk/reset_n:
//   en           detector enable
//   cfg_load     one-cycle configuration strobe
//   cfg_pattern  pattern, bit [cfg_len-1] received first, bit 0 last
//   cfg_len      pattern length (legal 1..MAX_LEN)
//   cfg_overlap  1 = overlapping detection
//   in_valid     qualifies seq_in
//   seq_in       serial data bit
//   det_out      registered one-cycle detect pulse
//   armed        detector is in ACTIVE
//   cfg_err      one-cycle pulse after a cfg_load with an illegal length
//   match_count  saturating detection count (zero when the counter is not built)
//
// master: the side that drives the stream and configuration.
// slave:  the detector.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               en;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               in_valid;
  logic               seq_in;
  logic               det_out;
  logic               armed;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output en, cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, seq_in,
    input  det_out, armed, cfg_err, match_count
  );

  modport slave (
    input  en, cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, seq_in,
    output det_out, armed, cfg_err, match_count
  );
endinterface

// File: rtl/seq_detector_prog.sv
// seq_detector_prog -- programmable serial pattern detector (sync-word search).
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (also clears the shadow config)
//   bus      seq_detector_prog_if.slave: enable, config load, serial input,
//            detect pulse, armed, cfg_err, match_count
//
// Optional build macro SEQDET_MATCH_COUNT_EN: when defined, a saturating
// CNT_W-bit match counter is built; otherwise match_count is tied to 0.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | not armed; in_valid ignored, det_out held 0; waits for cfg_load
// ACTIVE | armed; shifts qualified bits into history and detects matches
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            reset_n,
  seq_detector_prog_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  // Only MAX_LEN-1 past bits are kept: together with the incoming bit they
  // form the full MAX_LEN-bit comparison window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_q, det_d;
  logic               err_q, err_d;

  logic               cfg_legal;
  logic               sample;
  logic               match;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_nxt;

  // Match is evaluated on the post-shift window so det_out lands one clock
  // after the final pattern bit is presented.
  always_comb begin
    cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    hist_nxt  = {hist_q, bus.seq_in};
    fill_nxt  = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    // cfg_load takes priority over a coincident data bit, which is dropped.
    sample = (state_q == ACTIVE) && bus.en && bus.in_valid && !bus.cfg_load;
    match  = sample && (fill_nxt >= len_q) &&
             (((hist_nxt ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    err_d   = bus.cfg_load && !cfg_legal;

    case (state_q)
      IDLE: begin
        if (bus.cfg_load && bus.en && cfg_legal) begin
          state_d = ACTIVE;
          pat_d   = bus.cfg_pattern;
          len_d   = bus.cfg_len;
          ovl_d   = bus.cfg_overlap;
          hist_d  = '0;
          fill_d  = '0;
        end
      end
      ACTIVE: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (bus.cfg_load) begin
          if (cfg_legal) begin
            pat_d  = bus.cfg_pattern;
            len_d  = bus.cfg_len;
            ovl_d  = bus.cfg_overlap;
            hist_d = '0;
            fill_d = '0;
          end
        end else if (bus.in_valid) begin
          hist_d = hist_nxt[MAX_LEN-2:0];
          // Non-overlapping mode demands len fresh bits after each hit.
          fill_d = (match && !ovl_q) ? '0 : fill_nxt;
          det_d  = match;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      err_q   <= err_d;
    end
  end

  assign bus.det_out = det_q;
  assign bus.armed   = (state_q == ACTIVE);
  assign bus.cfg_err = err_q;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Advances on the same edge that raises det_out, so the count and the
  // pulse become visible together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.match_count = cnt_q;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog -- scoreboard bench for seq_detector_prog
// (MAX_LEN=8, CNT_W=4). Stimulus pushes the expected post-edge outputs for
// every driven cycle; a monitor pops and compares just after each rising edge.
module tb_seq_detector_prog;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;

  logic clk;
  logic reset_n;

  seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit det;
    bit arm;
    bit err;
    int cnt;
    int tag;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   tnum  = 0;
  int   ecnt  = 0;

  logic [7:0] pat_v = '0;
  logic [3:0] len_v = 4'd1;
  logic       ovl_v = 1'b0;
  logic       en_v  = 1'b1;

  task automatic chk(input string nm, input int tag, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s t%0d actual=%0d required=%0d", nm, tag, act, req);
    end
  endtask

  function automatic int cnt_exp(input int n);
`ifdef SEQDET_MATCH_COUNT_EN
    return (n > 15) ? 15 : n;
`else
    return (n >= 0) ? 0 : 0;
`endif
  endfunction

  // Drive one cycle at the falling edge and queue the outputs expected
  // after the following rising edge.
  task automatic step(input bit ld, input bit vld, input bit b,
                      input bit e_det, input bit e_arm, input bit e_err);
    exp_t e;
    @(negedge clk);
    bus.en          = en_v;
    bus.cfg_pattern = pat_v;
    bus.cfg_len     = len_v;
    bus.cfg_overlap = ovl_v;
    bus.cfg_load    = ld;
    bus.in_valid    = vld;
    bus.seq_in      = b;
    if (e_det) ecnt++;
    e.det = e_det;
    e.arm = e_arm;
    e.err = e_err;
    e.cnt = cnt_exp(ecnt);
    e.tag = tnum;
    sb_q.push_back(e);
  endtask

  // Feed n bits MSB-first on consecutive valid cycles while armed.
  task automatic run_bits(input logic [31:0] bits, input logic [31:0] dets, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, bits[i], dets[i], 1'b1, 1'b0);
    end
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_det", tnum, bus.det_out, 0);
    chk("rst_armed", tnum, bus.armed, 0);
    chk("rst_err", tnum, bus.cfg_err, 0);
    chk("rst_cnt", tnum, bus.match_count, 0);
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
    bus.seq_in   = 1'b0;
    ecnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("det_out", e.tag, bus.det_out, e.det);
        chk("armed", e.tag, bus.armed, e.arm);
        chk("cfg_err", e.tag, bus.cfg_err, e.err);
        chk("match_count", e.tag, bus.match_count, e.cnt);
      end
    end
  end

  initial begin : stim
    reset_n          = 1'b0;
    bus.en           = 1'b1;
    bus.cfg_load     = 1'b0;
    bus.cfg_pattern  = '0;
    bus.cfg_len      = 4'd1;
    bus.cfg_overlap  = 1'b0;
    bus.in_valid     = 1'b0;
    bus.seq_in       = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_det", 0, bus.det_out, 0);
    chk("init_armed", 0, bus.armed, 0);
    chk("init_err", 0, bus.cfg_err, 0);
    chk("init_cnt", 0, bus.match_count, 0);
    reset_n = 1'b1;

    // 1: 1011 overlapping, stream 1011011 -> hits on bits 4 and 7
    tnum = 1; pat_v = 8'h0B; len_v = 4'd4; ovl_v = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_bits(32'b1011011, 32'b0001001, 7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();

    // 2: same stream non-overlapping -> only bit 4
    tnum = 2; ovl_v = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_bits(32'b1011011, 32'b0001000, 7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();

    // 3: 1011 with three idle cycles after each bit
    tnum = 3; ovl_v = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    begin
      logic [3:0] b3;
      b3 = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        step(1'b0, 1'b1, b3[i], (i == 0), 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
    end
    do_reset();

    // 4: len=1 pattern 1, stream 1101; then illegal lengths while armed
    tnum = 4; pat_v = 8'h01; len_v = 4'd1; ovl_v = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_bits(32'b1101, 32'b1101, 4);
    len_v = 4'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    len_v = 4'd9; pat_v = 8'h00;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();

    // 4b: illegal length from IDLE stays unarmed
    tnum = 41; len_v = 4'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // 5: 8-bit A5, then cfg_load with in_valid discards the bit
    tnum = 5; pat_v = 8'hA5; len_v = 4'd8; ovl_v = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_bits(32'hA5, 32'h01, 8);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_bits(32'b01001011, 32'h00, 8);
    run_bits(32'hA5, 32'h01, 8);
    en_v = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    en_v = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_bits(32'hA5, 32'h01, 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();

    // 6: 20 single-bit matches saturate a 4-bit counter; reset lands
    // right after the last hit, then the detector needs a fresh cfg_load
    tnum = 6; pat_v = 8'h01; len_v = 4'd1; ovl_v = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    tnum = 61;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
    #2;
    chk("drain", 0, sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
